channel_serializer: RTL and testbench

CHANNEL_SERIALIZER -- requirements
Module: channel_serializer

---
 rtl/channel_serializer_pkg.sv | 12 +
 rtl/channel_serializer.sv | 80 ++++++++
 tb/tb_channel_serializer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_serializer_pkg.sv
// Shared types and constants for the channel serializer: FSM state encoding
// and the width of the transmitted-frame counter.
package channel_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/channel_serializer.sv
// Frame-to-word serializer: captures a CHANNEL-word frame and emits it one
// word per handshake, highest slice first, so a left-shift packer rebuilds it.
module channel_serializer
    import channel_serializer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CHANNEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNEL*WIDTH-1:0]   in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [FRAME_CNT_W-1:0]     frame_cnt
);

    localparam int               IDX_W    = $clog2(CHANNEL);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNEL - 1);

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CHANNEL*WIDTH-1:0]   frame_q, frame_d;
    logic [FRAME_CNT_W-1:0]     cnt_q, cnt_d;

    logic sending;
    logic last_word;
    logic accept;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;

        sending   = (state_q == SEND);
        last_word = (idx_q == '0);
        // Ready while the final word drains lets the next frame load with no bubble.
        in_ready  = !rst && (!sending || (last_word && out_ready));
        accept    = in_valid && in_ready;

        if (sending && out_ready) begin
            if (last_word) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end

        if (accept) begin
            frame_d = in_data;
            idx_d   = IDX_LAST;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = sending && !rst;
    assign out_last  = out_valid && last_word;
    assign out_data  = out_valid ? frame_q[int'(idx_q)*WIDTH +: WIDTH] : '0;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_channel_serializer.sv
// Self-checking bench for channel_serializer: directed vector table, hand-written
// reset/wrap sequences, and a randomized run against a queue-based reference model.
module tb_channel_serializer;

    localparam int W  = 32;
    localparam int CH = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [15:0]       frame_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    channel_serializer #(.WIDTH(W), .CHANNEL(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    task automatic check(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic            iv;
        logic            ordy;
        logic [CH*W-1:0] din;
        logic            ov;
        logic [W-1:0]    dout;
        logic            last;
        logic            ir;
        logic [15:0]     cnt;
    } vec_t;

    localparam logic [CH*W-1:0] FR_A = 96'h33333333_22222222_11111111;
    localparam logic [CH*W-1:0] FR_B = 96'h66666666_55555555_44444444;
    localparam logic [CH*W-1:0] FR_X = 96'hDEADBEEF_CAFEF00D_0BADC0DE;

    vec_t vecs[22];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic [CH*W-1:0] din,
                                input logic ov, input logic [W-1:0] dout, input logic last,
                                input logic ir, input logic [15:0] cnt);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.din = din; v.ov = ov;
        v.dout = dout; v.last = last; v.ir = ir; v.cnt = cnt;
        return v;
    endfunction

    // Advance to one time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [CH*W-1:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (CH) tick();
    endtask

    logic [W-1:0]    q_data[$];
    bit              q_last[$];
    logic [CH*W-1:0] q_frame[$];

    initial begin
        logic [CH*W-1:0] pack;
        logic [CH*W-1:0] orig;
        logic [W-1:0]    word;
        bit              wlast;
        bit              exp_ov, exp_ir, acc, tx;
        int              mcnt, accepted, done, cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        @(negedge clk);
        check("rst_in_ready",  {95'd0, in_ready},  '0);
        check("rst_out_valid", {95'd0, out_valid}, '0);
        check("rst_out_last",  {95'd0, out_last},  '0);
        check("rst_out_data",  {64'd0, out_data},  '0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {95'd0, in_ready}, 96'd1);
        check("post_rst_cnt",      {80'd0, frame_cnt}, '0);
        tick();

        // single frame, backpressure with in_data churn, back-to-back frames
        vecs[0]  = mk(1, 1, FR_A, 0, 32'h0,        0, 1, 0);
        vecs[1]  = mk(0, 1, FR_X, 1, 32'h33333333, 0, 0, 0);
        vecs[2]  = mk(0, 1, FR_X, 1, 32'h22222222, 0, 0, 0);
        vecs[3]  = mk(0, 1, FR_X, 1, 32'h11111111, 1, 1, 0);
        vecs[4]  = mk(0, 1, FR_X, 0, 32'h0,        0, 1, 1);
        vecs[5]  = mk(1, 1, FR_A, 0, 32'h0,        0, 1, 1);
        vecs[6]  = mk(0, 1, FR_X, 1, 32'h33333333, 0, 0, 1);
        vecs[7]  = mk(0, 0, FR_X, 1, 32'h22222222, 0, 0, 1);
        vecs[8]  = mk(1, 0, FR_X, 1, 32'h22222222, 0, 0, 1);
        vecs[9]  = mk(1, 0, FR_B, 1, 32'h22222222, 0, 0, 1);
        vecs[10] = mk(1, 0, FR_X, 1, 32'h22222222, 0, 0, 1);
        vecs[11] = mk(0, 1, FR_X, 1, 32'h22222222, 0, 0, 1);
        vecs[12] = mk(0, 1, FR_X, 1, 32'h11111111, 1, 1, 1);
        vecs[13] = mk(0, 1, FR_X, 0, 32'h0,        0, 1, 2);
        vecs[14] = mk(1, 1, FR_A, 0, 32'h0,        0, 1, 2);
        vecs[15] = mk(1, 1, FR_B, 1, 32'h33333333, 0, 0, 2);
        vecs[16] = mk(1, 1, FR_B, 1, 32'h22222222, 0, 0, 2);
        vecs[17] = mk(1, 1, FR_B, 1, 32'h11111111, 1, 1, 2);
        vecs[18] = mk(0, 1, FR_X, 1, 32'h66666666, 0, 0, 3);
        vecs[19] = mk(0, 1, FR_X, 1, 32'h55555555, 0, 0, 3);
        vecs[20] = mk(0, 1, FR_X, 1, 32'h44444444, 1, 1, 3);
        vecs[21] = mk(0, 1, FR_X, 0, 32'h0,        0, 1, 4);

        for (int i = 0; i < 22; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_data   = vecs[i].din;
            @(negedge clk);
            $display("vec %0d: ov=%0b data=%h last=%0b ir=%0b cnt=%0d",
                     i, out_valid, out_data, out_last, in_ready, frame_cnt);
            check($sformatf("vec%0d_out_valid", i), {95'd0, out_valid}, {95'd0, vecs[i].ov});
            check($sformatf("vec%0d_in_ready", i),  {95'd0, in_ready},  {95'd0, vecs[i].ir});
            check($sformatf("vec%0d_frame_cnt", i), {80'd0, frame_cnt}, {80'd0, vecs[i].cnt});
            if (vecs[i].ov) begin
                check($sformatf("vec%0d_out_data", i), {64'd0, out_data}, {64'd0, vecs[i].dout});
                check($sformatf("vec%0d_out_last", i), {95'd0, out_last}, {95'd0, vecs[i].last});
            end
            tick();
        end
        in_valid = 1'b0;

        // reset after the first word has been taken
        in_valid = 1'b1; in_data = FR_A; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_first_word", {64'd0, out_data}, {64'd0, 32'h33333333});
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ov_in_rst",  {95'd0, out_valid}, '0);
        check("midrst_ir_in_rst",  {95'd0, in_ready},  '0);
        check("midrst_data_in_rst", {64'd0, out_data}, '0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ov_after", {95'd0, out_valid}, '0);
        check("midrst_cnt_after", {80'd0, frame_cnt}, '0);
        $display("midrst: frame discarded, cnt=%0d", frame_cnt);
        in_valid = 1'b1; in_data = FR_B;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_restart_word", {64'd0, out_data}, {64'd0, 32'h66666666});
        repeat (CH) tick();
        @(negedge clk);
        check("midrst_restart_cnt", {80'd0, frame_cnt}, 96'd1);

        // counter wrap
        tick();
        force dut.cnt_q = 16'hFFFE;
        #2;
        release dut.cnt_q;
        send_frame(FR_A);
        @(negedge clk);
        check("wrap_ffff", {80'd0, frame_cnt}, {80'd0, 16'hFFFF});
        tick();
        send_frame(FR_B);
        @(negedge clk);
        check("wrap_zero", {80'd0, frame_cnt}, '0);
        $display("wrap: frame_cnt=%h", frame_cnt);

        // randomized run with round-trip repacking
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mcnt = 0; accepted = 0; done = 0; pack = '0;
        for (cyc = 0; cyc < 20000 && done < 100; cyc++) begin
            in_valid  = (accepted < 100) && ($urandom_range(0, 3) != 0);
            in_data   = {$urandom(), $urandom(), $urandom()};
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_ov = (q_data.size() != 0);
            exp_ir = (q_data.size() == 0) || (q_data.size() == 1 && out_ready);
            check("rnd_out_valid", {95'd0, out_valid}, {95'd0, exp_ov});
            check("rnd_in_ready",  {95'd0, in_ready},  {95'd0, exp_ir});
            check("rnd_frame_cnt", {80'd0, frame_cnt}, 96'(mcnt));
            if (exp_ov) begin
                check("rnd_out_data", {64'd0, out_data}, {64'd0, q_data[0]});
                check("rnd_out_last", {95'd0, out_last}, {95'd0, q_last[0]});
            end
            acc = in_valid && exp_ir;
            tx  = exp_ov && out_ready;
            tick();
            if (tx) begin
                word  = q_data.pop_front();
                wlast = q_last.pop_front();
                pack  = {pack[CH*W-W-1:0], word};
                if (wlast) begin
                    mcnt = (mcnt + 1) % 65536;
                    orig = q_frame.pop_front();
                    check("rnd_roundtrip", pack, orig);
                    $display("frame %0d: sent=%h repacked=%h", done, orig, pack);
                    done++;
                end
            end
            if (acc) begin
                for (int k = CH - 1; k >= 0; k--) begin
                    q_data.push_back(in_data[k*W +: W]);
                    q_last.push_back(k == 0);
                end
                q_frame.push_back(in_data);
                accepted++;
            end
        end
        in_valid = 1'b0;
        check("rnd_frames_done", 96'(done), 96'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
